// File: rtl/sum_accumulator_if.sv
// Bus between the sumItUp stage/consumers and sum_accumulator.
// The master drives capture/pop controls; the slave returns totals and the history head.
interface sum_accumulator_if #(
    parameter int W = 8
);
    logic [W-1:0] pot_val;
    logic         load;
    logic         clear;
    logic         hist_pop;
    logic [W-1:0] sum;
    logic         sum_valid;
    logic         overflow;
    logic [7:0]   load_count;
    logic [W-1:0] hist_data;
    logic         hist_empty;
    logic         hist_full;

    modport master (
        output pot_val, load, clear, hist_pop,
        input  sum, sum_valid, overflow, load_count, hist_data, hist_empty, hist_full
    );

    modport slave (
        input  pot_val, load, clear, hist_pop,
        output sum, sum_valid, overflow, load_count, hist_data, hist_empty, hist_full
    );
endinterface

// File: rtl/sum_accumulator.sv
// Edge-qualified capture of sumItUp results into a running total, capture counter and history FIFO.
// Build option SUM_ACCUMULATOR_SATURATE_EN: sum clamps at all-ones on carry instead of wrapping.
//
// state | meaning
// IDLE  | load low seen; next load=1 is a fresh edge and captures
// HELD  | load edge already consumed; wait for load to fall
module sum_accumulator #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input logic            clk,
    input logic            rst,
    sum_accumulator_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic {IDLE, HELD} state_t;

    state_t         state;
    state_t         state_nxt;
    logic           capture;
    logic [W:0]     add_full;
    logic [W-1:0]   sum_nxt;
    logic [W-1:0]   sum_q;
    logic           ovf_q;
    logic           valid_q;
    logic [7:0]     cnt_q;
    logic [W-1:0]   mem [DEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic [CW-1:0]  count;
    logic           push;
    logic           pop;
    logic           empty;
    logic           full;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A load edge that coincides with clear still moves the FSM to HELD, so it is consumed.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.load) begin
                    capture   = ~bus.clear;
                    state_nxt = HELD;
                end
            end
            HELD: begin
                if (!bus.load) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        add_full = {1'b0, sum_q} + {1'b0, bus.pot_val};
`ifdef SUM_ACCUMULATOR_SATURATE_EN
        sum_nxt = add_full[W] ? {W{1'b1}} : add_full[W-1:0];
`else
        sum_nxt = add_full[W-1:0];
`endif
    end

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign push  = capture;
    assign pop   = bus.hist_pop & ~empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q   <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
        end else begin
            valid_q <= capture;
            if (bus.clear) begin
                sum_q  <= '0;
                ovf_q  <= 1'b0;
                cnt_q  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (capture) begin
                    sum_q <= sum_nxt;
                    ovf_q <= ovf_q | add_full[W];
                    cnt_q <= cnt_q + 8'd1;
                end
                // Push onto a full buffer drops the oldest entry, so rd_ptr moves as if popped.
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop || (push && full)) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                if (push && !pop && !full) begin
                    count <= count + CW'(1);
                end else if (pop && !push) begin
                    count <= count - CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr] <= bus.pot_val;
        end
    end

    assign bus.sum        = sum_q;
    assign bus.sum_valid  = valid_q & ~rst & ~bus.clear;
    assign bus.overflow   = ovf_q;
    assign bus.load_count = cnt_q;
    assign bus.hist_data  = empty ? '0 : mem[rd_ptr];
    assign bus.hist_empty = empty;
    assign bus.hist_full  = full;
endmodule
